// File: rtl/rv_pkg.sv
// Shared core constants: datapath width, register-file geometry and the
// fixed writeback requester indices.
package rv_pkg;

  localparam int XLEN     = 64;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam int WB_ALU    = 0;
  localparam int WB_LSU    = 1;
  localparam int WB_MULDIV = 2;

endpackage : rv_pkg

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the search starts at ptr_i and wraps modulo N.
// Produces a one-hot grant and the pointer value to use after that grant.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] next_ptr_o
);

  always_comb begin
    logic found;
    int   idx;
    gnt_o      = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        next_ptr_o = PW'((idx + 1) % N);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/rf_wb_scheduler.sv
// Round-robin sharing of the register-file write port between writeback
// sources, plus a per-register pending-write scoreboard for RAW stalls.
module rf_wb_scheduler
  import rv_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = rv_pkg::XLEN,
  parameter int CNT_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        wb_valid,
  output logic [NUM_REQ-1:0]        wb_ready,
  input  logic [NUM_REQ*REG_AW-1:0] wb_rd,
  input  logic [NUM_REQ*XLEN-1:0]   wb_data,
  input  logic                      claim_valid,
  input  logic [REG_AW-1:0]         claim_rd,
  output logic                      claim_ready,
  output logic [NUM_REGS-1:0]       busy_mask,
  output logic                      rf_write_en,
  output logic [REG_AW-1:0]         rf_write_reg,
  output logic [XLEN-1:0]           rf_write_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [PW-1:0]      ptr_q, ptr_d;
  logic               rf_en_q, rf_en_d;
  logic [REG_AW-1:0]  rf_reg_q, rf_reg_d;
  logic [XLEN-1:0]    rf_data_q, rf_data_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REGS];
  logic [CNT_W-1:0]   cnt_d [NUM_REGS];

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PW-1:0]      arb_next_ptr;
  logic               grant_any;
  logic [REG_AW-1:0]  gnt_rd;
  logic [XLEN-1:0]    gnt_data;
  logic               commit_hit_claim;
  logic               claim_fire;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i      (wb_valid),
    .ptr_i      (ptr_q),
    .gnt_o      (arb_gnt),
    .next_ptr_o (arb_next_ptr)
  );

  // Grants are suppressed while reset is held so nothing is consumed.
  assign wb_ready  = reset ? arb_gnt : '0;
  assign grant_any = |wb_ready;

  always_comb begin
    gnt_rd   = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wb_ready[i]) begin
        gnt_rd   = wb_rd[REG_AW*i +: REG_AW];
        gnt_data = wb_data[XLEN*i +: XLEN];
      end
    end
  end

  // A write to x0 is consumed but never reaches the register file.
  always_comb begin
    ptr_d     = grant_any ? arb_next_ptr : ptr_q;
    rf_en_d   = grant_any && (gnt_rd != '0);
    rf_reg_d  = rf_reg_q;
    rf_data_d = rf_data_q;
    if (rf_en_d) begin
      rf_reg_d  = gnt_rd;
      rf_data_d = gnt_data;
    end
  end

  assign commit_hit_claim = rf_en_q && (rf_reg_q == claim_rd);
  assign claim_ready      = (claim_rd == '0) || (cnt_q[claim_rd] != CNT_SAT) || commit_hit_claim;
  assign claim_fire       = claim_valid && claim_ready && (claim_rd != '0);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (claim_fire && (claim_rd == REG_AW'(r))) begin
        if (!(rf_en_q && (rf_reg_q == REG_AW'(r)))) begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end
      end else if (rf_en_q && (rf_reg_q == REG_AW'(r)) && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q     <= '0;
      rf_en_q   <= 1'b0;
      rf_reg_q  <= '0;
      rf_data_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      ptr_q     <= ptr_d;
      rf_en_q   <= rf_en_d;
      rf_reg_q  <= rf_reg_d;
      rf_data_q <= rf_data_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    if (gi == 0) begin : g_x0
      assign busy_mask[gi] = 1'b0;
    end else begin : g_reg
      assign busy_mask[gi] = (cnt_q[gi] != '0);
    end
  end

  assign rf_write_en   = rf_en_q;
  assign rf_write_reg  = rf_reg_q;
  assign rf_write_data = rf_data_q;

endmodule : rf_wb_scheduler
